pipe_adder: RTL
===============

PIPE_ADDER -- requirements
Module: pipe_adder

Interface
REQ-001 Parameter WIDTH, default 32; operand and result width in bits, legal 8..64.
REQ-002 Parameter SEGS, default 4; number of pipelined carry segments; WIDTH SHALL be divisible by SEGS; legal 1..8.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  operand beat offered.
REQ-006 in_ready  output  1  block accepts a beat this cycle.
REQ-007 op  input  2  00 ADD, 01 SUB, 10 ADC, 11 SBC.
REQ-008 a, b  input  WIDTH each  unsigned/two's-complement operands.
REQ-009 cin  input  1  carry-in, used by ADC/SBC only.
REQ-010 out_valid  output  1  result beat present.
REQ-011 out_ready  input  1  downstream accepts the result beat.
REQ-012 sum  output  WIDTH  result.
REQ-013 cout  output  1  carry out of MSB; for SUB/SBC, 1 means no borrow.
REQ-014 ovf  output  1  signed overflow.
REQ-015 zero  output  1  sum == 0.

Function
REQ-016 Transfer SHALL occur on in_valid && in_ready (accept) and on out_valid && out_ready (drain).
REQ-017 Effective operation: ADD a+b+0; SUB a+~b+1; ADC a+b+cin; SBC a+~b+cin; computed modulo 2^WIDTH.
REQ-018 Stage 0 registers the operands. Stage k (1..SEGS) adds slice k-1 (WIDTH/SEGS bits, LSB first) with the carry from stage k-1. Upper slices are delayed alongside.
REQ-019 Latency SHALL be exactly SEGS+1 cycles from accept to out_valid, absent stalls.
REQ-020 Throughput SHALL be one beat per cycle when out_ready is held high.
REQ-021 Stall: when out_valid && !out_ready, the whole pipeline SHALL hold and in_ready SHALL be 0; otherwise in_ready = !rst.
REQ-022 Beats SHALL leave in acceptance order, with none dropped or duplicated.
REQ-023 Bubbles (in_valid=0) SHALL propagate as invalid stages and SHALL NOT assert out_valid.
REQ-024 ovf SHALL be 1 when the effective operands share a sign bit and sum's sign bit differs from it.
REQ-025 sum, cout, ovf and zero SHALL stay stable while out_valid && !out_ready.
REQ-026 Simultaneous accept and drain in the same cycle SHALL both complete.

Reset
REQ-027 While rst=1: all stage valid bits are 0, out_valid=0, sum=0, cout=0, ovf=0, zero=0, in_ready=0.
REQ-028 Reset asserted mid-operation SHALL discard all in-flight beats; no result SHALL emerge from them after rst deasserts.
REQ-029 In the first cycle after rst deasserts, in_ready=1.

Configuration
REQ-030 Macro PIPE_ADDER_SAT_EN, when defined, adds input port sat (1 bit, captured with the operands).
REQ-031 With PIPE_ADDER_SAT_EN and sat=1, a signed overflow SHALL clamp sum to the most positive value (positive overflow) or the most negative value (negative overflow). ovf still reports 1, zero reflects the clamped sum, and cout is unchanged.
REQ-032 Without PIPE_ADDER_SAT_EN, the sat port SHALL be absent and results SHALL always wrap around.

Structure
REQ-033 Package pipe_adder_pkg SHALL hold the op encoding typedef (ADD/SUB/ADC/SBC) and the legal WIDTH/SEGS limits.
REQ-034 One slice stage SHALL be the sub-module adder_seg: registered slice sum plus carry, with a hold enable; pipe_adder instantiates SEGS of them.
REQ-035 Flag logic and saturation SHALL reside in the final stage of pipe_adder.

Verification (WIDTH=8, SEGS=2, latency 3)
REQ-036 ADD a=0xFF, b=0x01 -> after 3 cycles sum=0x00, cout=1, zero=1, ovf=0.
REQ-037 SUB a=0x80, b=0x01 -> sum=0x7F, cout=1, ovf=1; with PIPE_ADDER_SAT_EN and sat=1 -> sum=0x80, ovf=1.
REQ-038 Back-to-back ADC beats (0x10+0x20+cin 1, 0x7F+0x01+cin 0) with out_ready=1 -> on consecutive cycles sum=0x31, then 0x80 with ovf=1.
REQ-039 Hold out_ready=0 for 5 cycles with 3 beats in flight -> in_ready=0 and outputs frozen; on release, 3 results drain in order with no loss.
REQ-040 Assert rst for 1 cycle with 2 beats in flight -> out_valid stays 0 for the next 4 cycles, and in_ready=1 in the first cycle after reset.

Source files
------------

// File: rtl/pipe_adder_pkg.sv
// Shared definitions for pipe_adder: operation encoding and legal parameter limits.
package pipe_adder_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_ADC = 2'b10,
    OP_SBC = 2'b11
  } op_e;

  localparam int PA_MIN_WIDTH = 8;
  localparam int PA_MAX_WIDTH = 64;
  localparam int PA_MIN_SEGS  = 1;
  localparam int PA_MAX_SEGS  = 8;

  // Subtracting operations feed the inverted b operand into the adder chain.
  function automatic logic is_sub(input op_e op);
    return (op == OP_SUB) || (op == OP_SBC);
  endfunction

endpackage

// File: rtl/adder_seg.sv
// One carry segment of pipe_adder: a registered SW-bit slice sum and carry-out.
module adder_seg #(
  parameter int SW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_en,
  input  logic [SW-1:0] i_a,
  input  logic [SW-1:0] i_b,
  input  logic          i_c,
  output logic [SW-1:0] o_sum,
  output logic          o_c
);

  logic [SW:0]   w_full;
  logic [SW-1:0] r_sum;
  logic          r_c;

  assign w_full = {1'b0, i_a} + {1'b0, i_b} + {{SW{1'b0}}, i_c};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sum <= '0;
      r_c   <= 1'b0;
    end else if (i_en) begin
      r_sum <= w_full[SW-1:0];
      r_c   <= w_full[SW];
    end
  end

  assign o_sum = r_sum;
  assign o_c   = r_c;

endmodule

// File: rtl/pipe_adder.sv
// Pipelined add/subtract with SEGS carry segments, latency SEGS+1, full-pipeline stall.
// Optional saturation on signed overflow when PIPE_ADDER_SAT_EN is defined (adds port sat).
module pipe_adder
  import pipe_adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SEGS  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef PIPE_ADDER_SAT_EN
  input  logic             sat,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int SW = WIDTH / SEGS;
  localparam logic [WIDTH-1:0] MOST_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  if ((WIDTH < PA_MIN_WIDTH) || (WIDTH > PA_MAX_WIDTH) || (SEGS < PA_MIN_SEGS) ||
      (SEGS > PA_MAX_SEGS) || ((WIDTH % SEGS) != 0)) begin : g_bad_cfg
    $error("pipe_adder: illegal WIDTH/SEGS combination");
  end

  // Handshake: a beat moves on in_valid && in_ready (accept) and on
  // out_valid && out_ready (drain); a held result freezes every stage.
  logic w_adv;
  logic r_out_valid;
  assign w_adv    = !(r_out_valid && !out_ready);
  assign in_ready = !rst && w_adv;

  op_e              w_op;
  logic [WIDTH-1:0] w_b_eff;
  logic             w_c_eff;

  assign w_op = op_e'(op);

  always_comb begin
    w_b_eff = is_sub(w_op) ? ~b : b;
    w_c_eff = 1'b0;
    case (w_op)
      OP_ADD:  w_c_eff = 1'b0;
      OP_SUB:  w_c_eff = 1'b1;
      OP_ADC:  w_c_eff = cin;
      OP_SBC:  w_c_eff = cin;
      default: w_c_eff = 1'b0;
    endcase
  end

  // Stage k holds operands still to be summed, the partial sum below slice k-1
  // and the operand sign bits needed for the overflow flag.
  logic [WIDTH-1:0] r_a   [SEGS];
  logic [WIDTH-1:0] r_b   [SEGS];
  logic [WIDTH-1:0] r_s   [1:SEGS];
  logic             r_v   [SEGS+1];
  logic             r_sa  [SEGS+1];
  logic             r_sb  [SEGS+1];
  logic             r_c0;
`ifdef PIPE_ADDER_SAT_EN
  logic             r_sat [SEGS+1];
`endif

  logic [WIDTH-1:0] w_s       [SEGS+1];
  logic             w_c       [SEGS+1];
  logic [SW-1:0]    w_seg_sum [1:SEGS];

  assign w_s[0] = '0;
  assign w_c[0] = r_c0;

  for (genvar k = 1; k <= SEGS; k++) begin : g_seg
    adder_seg #(.SW(SW)) u_seg (
      .clk   (clk),
      .rst   (rst),
      .i_en  (w_adv),
      .i_a   (r_a[k-1][(k-1)*SW +: SW]),
      .i_b   (r_b[k-1][(k-1)*SW +: SW]),
      .i_c   (w_c[k-1]),
      .o_sum (w_seg_sum[k]),
      .o_c   (w_c[k])
    );
    assign w_s[k] = r_s[k] | (WIDTH'(w_seg_sum[k]) << ((k-1)*SW));
  end

  // Final stage: flags and optional clamp on the fully assembled sum.
  logic [WIDTH-1:0] w_raw;
  logic [WIDTH-1:0] w_fsum;
  logic             w_fovf;

  assign w_raw  = w_s[SEGS];
  assign w_fovf = (r_sa[SEGS] == r_sb[SEGS]) && (w_raw[WIDTH-1] != r_sa[SEGS]);

`ifdef PIPE_ADDER_SAT_EN
  assign w_fsum = (w_fovf && r_sat[SEGS]) ? (r_sa[SEGS] ? MOST_NEG : MOST_POS) : w_raw;
`else
  assign w_fsum = w_raw;
`endif

  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;
  logic             r_zero;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k <= SEGS; k++) begin
        r_v[k]   <= 1'b0;
        r_sa[k]  <= 1'b0;
        r_sb[k]  <= 1'b0;
`ifdef PIPE_ADDER_SAT_EN
        r_sat[k] <= 1'b0;
`endif
      end
      for (int k = 0; k < SEGS; k++) begin
        r_a[k] <= '0;
        r_b[k] <= '0;
      end
      for (int k = 1; k <= SEGS; k++) begin
        r_s[k] <= '0;
      end
      r_c0        <= 1'b0;
      r_out_valid <= 1'b0;
      r_sum       <= '0;
      r_cout      <= 1'b0;
      r_ovf       <= 1'b0;
      r_zero      <= 1'b0;
    end else if (w_adv) begin
      r_v[0]  <= in_valid;
      r_a[0]  <= a;
      r_b[0]  <= w_b_eff;
      r_c0    <= w_c_eff;
      r_sa[0] <= a[WIDTH-1];
      r_sb[0] <= w_b_eff[WIDTH-1];
`ifdef PIPE_ADDER_SAT_EN
      r_sat[0] <= sat;
`endif
      for (int k = 1; k <= SEGS; k++) begin
        r_v[k]  <= r_v[k-1];
        r_sa[k] <= r_sa[k-1];
        r_sb[k] <= r_sb[k-1];
        r_s[k]  <= w_s[k-1];
`ifdef PIPE_ADDER_SAT_EN
        r_sat[k] <= r_sat[k-1];
`endif
      end
      for (int k = 1; k < SEGS; k++) begin
        r_a[k] <= r_a[k-1];
        r_b[k] <= r_b[k-1];
      end
      r_out_valid <= r_v[SEGS];
      if (r_v[SEGS]) begin
        r_sum  <= w_fsum;
        r_cout <= w_c[SEGS];
        r_ovf  <= w_fovf;
        r_zero <= (w_fsum == '0);
      end
    end
  end

  assign out_valid = r_out_valid;
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign ovf       = r_ovf;
  assign zero      = r_zero;

endmodule
